streaming_maxpool_2x2: RTL



---
 rtl/maxpool_pkg.sv | 38 +++
 rtl/maxpool_linebuf.sv | 26 ++
 rtl/streaming_maxpool_2x2.sv | 113 +++++++++++
 3 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the streaming 2x2 max-pool stage.
package maxpool_pkg;

  // Position of a beat inside its 2x2 window: {row odd, col odd}.
  typedef enum logic [1:0] {
    PH_LOAD    = 2'b00,  // top-left: seed the partial maximum
    PH_MERGE_H = 2'b01,  // top-right: fold into partial maximum
    PH_MERGE_V = 2'b10,  // bottom-left: fold into partial maximum
    PH_EMIT    = 2'b11   // bottom-right: window complete, emit result
  } phase_e;

  // Counter/address width for a range of n values; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Line-buffer depth: one partial maximum per pooled column per channel.
  function automatic int unsigned buf_depth(input int unsigned ifm_dim,
                                            input int unsigned num_ch);
    return (ifm_dim / 2) * num_ch;
  endfunction

  // Max of two zero-extended elements of the given width. For signed data the
  // sign bit is flipped so an unsigned compare orders two's-complement values.
  function automatic logic [31:0] max_elem(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width,
                                           input bit          is_signed);
    logic [31:0] bias;
    logic [31:0] a_key;
    logic [31:0] b_key;
    bias  = is_signed ? (32'd1 << (width - 1)) : 32'd0;
    a_key = a ^ bias;
    b_key = b ^ bias;
    return (a_key >= b_key) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Pooled-row line buffer: asynchronous read, synchronous write, no reset.
module maxpool_linebuf #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the partial maximum for the addressed column/channel slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Combinational read so the merge happens in the same cycle as the beat.
  assign rdata = mem[addr];

endmodule

// File: rtl/streaming_maxpool_2x2.sv
// Streaming 2x2 / stride-2 max-pool over raster-ordered, channel-innermost data.
module streaming_maxpool_2x2
  import maxpool_pkg::*;
#(
  parameter int unsigned IFM_DIM = 32,
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned WIDTH   = 8,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY
);

  localparam int unsigned BUF_DEPTH = buf_depth(IFM_DIM, NUM_CH);
  localparam int unsigned CH_W      = cnt_width(NUM_CH);
  localparam int unsigned DIM_W     = cnt_width(IFM_DIM);
  localparam int unsigned IDX_W     = cnt_width(BUF_DEPTH);

  // Reject unsupported geometries at elaboration.
  if (IFM_DIM < 2 || (IFM_DIM % 2) != 0) begin : g_bad_dim
    $error("streaming_maxpool_2x2: IFM_DIM must be even and >= 2");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("streaming_maxpool_2x2: NUM_CH must be >= 1");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("streaming_maxpool_2x2: WIDTH must be in 1..32");
  end

  logic [CH_W-1:0]  ch_q;
  logic [DIM_W-1:0] col_q;
  logic [DIM_W-1:0] row_q;

  logic             accept_c;
  logic             ch_last_c;
  logic             col_last_c;
  logic             row_last_c;
  phase_e           phase_c;
  logic [IDX_W-1:0] idx_c;
  logic [WIDTH-1:0] buf_rdata;
  logic [WIDTH-1:0] max_c;
  logic             buf_we_c;
  logic [WIDTH-1:0] buf_wdata_c;

  // Upstream may push whenever the output slot is empty or draining this cycle.
  assign in0_V_TREADY = !out_V_TVALID || out_V_TREADY;

  // Beat decode: window phase, buffer slot, running maximum and write enable.
  always_comb begin
    accept_c    = in0_V_TVALID && in0_V_TREADY;
    ch_last_c   = (ch_q  == CH_W'(NUM_CH - 1));
    col_last_c  = (col_q == DIM_W'(IFM_DIM - 1));
    row_last_c  = (row_q == DIM_W'(IFM_DIM - 1));
    phase_c     = phase_e'({row_q[0], col_q[0]});
    idx_c       = IDX_W'(32'(col_q >> 1) * NUM_CH + 32'(ch_q));
    max_c       = WIDTH'(max_elem(32'(buf_rdata), 32'(in0_V_TDATA), WIDTH, SIGNED));
    buf_we_c    = accept_c && (phase_c != PH_EMIT);
    buf_wdata_c = (phase_c == PH_LOAD) ? in0_V_TDATA : max_c;
  end

  // Raster position counters: channel innermost, then column, then row.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ch_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      if (ch_last_c) begin
        ch_q <= '0;
        if (col_last_c) begin
          col_q <= '0;
          row_q <= row_last_c ? '0 : row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end else begin
        ch_q <= ch_q + CH_W'(1);
      end
    end
  end

  // Output register: load on a window-completing beat, clear once consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_V_TVALID <= 1'b0;
      out_V_TDATA  <= '0;
    end else if (accept_c && (phase_c == PH_EMIT)) begin
      out_V_TVALID <= 1'b1;
      out_V_TDATA  <= max_c;
    end else if (out_V_TREADY) begin
      out_V_TVALID <= 1'b0;
    end
  end

  maxpool_linebuf #(
    .DEPTH  (BUF_DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (IDX_W)
  ) u_linebuf (
    .clk   (ap_clk),
    .we    (buf_we_c),
    .addr  (idx_c),
    .wdata (buf_wdata_c),
    .rdata (buf_rdata)
  );

endmodule
